// File: rtl/stream_window_source.sv
// stream_window_source
//   Transmitter end of the rts/rtr/sow/eow stream protocol. A start command
//   latches a base address and a length. The block then reads that many
//   words from a synchronous-read memory and sends them downstream as one
//   framed window: sow_o marks the first word and eow_o marks the last.
//
// Handshake: a word moves on every cycle where rts_o=1 and rtr_i=1. Once
//   rts_o is asserted it stays high, and data_o/sow_o/eow_o stay stable,
//   until that transfer happens.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           start command (sampled only while busy_o=0)
//   base_addr_i       first address of the window (sampled with start_i)
//   len_i             number of words in the window (sampled with start_i)
//   busy_o            window in progress (RUN, DRAIN, DONE)
//   done_o            one-cycle pulse when the window is complete
//   mem_en_o          memory read enable
//   mem_addr_o        memory read address
//   mem_data_i        read data, valid the cycle after mem_en_o=1
//   rtr_i             downstream ready to receive
//   rts_o             ready to send (output FIFO not empty)
//   sow_o, eow_o      start/end of window, qualify data_o
//   data_o            stream data
module stream_window_source #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  rtr_i,
  output logic                  rts_o,
  output logic                  sow_o,
  output logic                  eow_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    rd_idx_q, rd_idx_d;      // index of the next read
  logic                    inflight_q, inflight_d;  // read issued last cycle
  logic                    infl_sow_q, infl_sow_d;
  logic                    infl_eow_q, infl_eow_d;

  // 2-entry output FIFO; each entry carries data plus its framing bits.
  logic [DATA_WIDTH-1:0]   fifo_data_q [2];
  logic [DATA_WIDTH-1:0]   fifo_data_d [2];
  logic [1:0]              fifo_sow_q, fifo_sow_d;
  logic [1:0]              fifo_eow_q, fifo_eow_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;

  logic                    push;
  logic                    pop;
  logic                    issue;
  logic                    last_read;
  logic                    head_eow;
  logic [2:0]              pending;

  assign rts_o      = (count_q != 2'd0);
  assign pop        = rts_o && rtr_i;
  assign push       = inflight_q;
  assign head_eow   = fifo_eow_q[rd_ptr_q];
  assign last_read  = (rd_idx_q == (len_q - LEN_ONE));
  assign mem_addr_o = addr_q;

  // Words buffered plus words in flight, less the word leaving this cycle.
  // Counting the departing word lets a read go out on every cycle while
  // data streams, yet the FIFO can never be pushed while full.
  assign pending = {1'b0, count_q} + 3'(inflight_q) - 3'(pop);
  assign issue   = (state_q == S_RUN) && (pending < 3'd2);

  // Only the FIFO head is presented; an empty FIFO shows all zeros.
  assign data_o = rts_o ? fifo_data_q[rd_ptr_q] : '0;
  assign sow_o  = rts_o && fifo_sow_q[rd_ptr_q];
  assign eow_o  = rts_o && head_eow;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = (len_i == '0) ? S_DONE : S_RUN;
      S_RUN:   if (issue && last_read) state_d = S_DRAIN;
      // The eow word is always the last one out, so its transfer means the
      // FIFO and the read pipeline are both empty.
      S_DRAIN: if (pop && head_eow) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o   = (state_q != S_IDLE);
    done_o   = (state_q == S_DONE);
    mem_en_o = issue;
  end

  // Read sequencing and FIFO bookkeeping
  always_comb begin
    addr_d      = addr_q;
    len_d       = len_q;
    rd_idx_d    = rd_idx_q;
    inflight_d  = issue;
    infl_sow_d  = issue && (rd_idx_q == '0);
    infl_eow_d  = issue && last_read;
    fifo_data_d = fifo_data_q;
    fifo_sow_d  = fifo_sow_q;
    fifo_eow_d  = fifo_eow_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + 2'(push) - 2'(pop);

    if ((state_q == S_IDLE) && start_i) begin
      addr_d   = base_addr_i;
      len_d    = len_i;
      rd_idx_d = '0;
    end
    if (issue) begin
      addr_d   = addr_q + 1'b1;  // wraps naturally modulo 2^ADDR_WIDTH
      rd_idx_d = rd_idx_q + LEN_ONE;
    end
    if (push) begin
      fifo_data_d[wr_ptr_q] = mem_data_i;
      fifo_sow_d[wr_ptr_q]  = infl_sow_q;
      fifo_eow_d[wr_ptr_q]  = infl_eow_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= '0;
      len_q          <= '0;
      rd_idx_q       <= '0;
      inflight_q     <= 1'b0;
      infl_sow_q     <= 1'b0;
      infl_eow_q     <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_sow_q     <= '0;
      fifo_eow_q     <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      addr_q         <= addr_d;
      len_q          <= len_d;
      rd_idx_q       <= rd_idx_d;
      inflight_q     <= inflight_d;
      infl_sow_q     <= infl_sow_d;
      infl_eow_q     <= infl_eow_d;
      fifo_data_q    <= fifo_data_d;
      fifo_sow_q     <= fifo_sow_d;
      fifo_eow_q     <= fifo_eow_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

endmodule

// File: tb/tb_stream_window_source.sv
module tb_stream_window_source;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int LW = 8;
  localparam int OW = DW + 2;  // {sow, eow, data}

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] len_i;
  logic          busy_o, done_o, mem_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_i;
  logic          rtr_i;
  logic          rts_o, sow_o, eow_o;
  logic [DW-1:0] data_o;

  always #5 clk = ~clk;

  stream_window_source #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .mem_en_o(mem_en_o),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i), .rtr_i(rtr_i),
    .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o), .data_o(data_o)
  );

  // Synchronous-read memory model: one cycle of latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) if (mem_en_o) mem_data_i <= mem[mem_addr_o];

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            failures = 0;
  logic [OW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [OW-1:0] obs_q[$];
  int            obs_cyc_q[$];
  logic [AW-1:0] addr_obs_q[$];
  int            done_cyc_q[$];
  int            stable_err, credit_err;
  bit            rts_seen, timed_out;
  logic          busy_after_done;

  // Reference model: a window is simply len consecutive memory words,
  // addresses modulo 256, first tagged sow, last tagged eow.
  task automatic model_window(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < len; i++) begin
      a = AW'(int'(base) + i);
      exp_addr_q.push_back(a);
      exp_q.push_back({(i == 0), (i == len - 1), mem[a]});
    end
  endtask

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < 256; i++) mem[i] = ramp ? DW'(i + 16'h0100) : DW'($urandom);
  endtask

  // ---------------- driver ----------------
  // Cycle 0 is the cycle in which start_i is high. Inputs for a cycle are
  // set on the falling edge, outputs are sampled 1 time unit later.
  // mode: 0 = rtr always high, 1 = rtr pattern 1,0,0,1,0,1..., 2 = random.
  task automatic run_window(input logic [AW-1:0] base, input logic [LW-1:0] len,
                            input int mode, input int stray_cyc,
                            input int abort_after, input bit linger);
    int cyc, done_at, issued, xfers;
    bit fin, xfer_now, prev_stall;
    logic [OW-1:0] prev_out;
    obs_q.delete(); obs_cyc_q.delete(); addr_obs_q.delete(); done_cyc_q.delete();
    stable_err = 0; credit_err = 0; rts_seen = 0; timed_out = 0;
    busy_after_done = 1'bx;
    cyc = 0; done_at = -1; issued = 0; xfers = 0; fin = 0; prev_stall = 0;
    prev_out = '0;
    while (!fin) begin
      @(negedge clk);
      start_i     = (cyc == 0) || (cyc == stray_cyc);
      base_addr_i = (cyc == 0) ? base : 8'h40;
      len_i       = (cyc == 0) ? len : 8'd3;
      case (mode)
        0:       rtr_i = 1'b1;
        1:       rtr_i = ((cyc % 6) == 0) || ((cyc % 6) == 3) || ((cyc % 6) == 5);
        default: rtr_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (prev_stall && (!rts_o || ({sow_o, eow_o, data_o} !== prev_out))) stable_err++;
      xfer_now = rts_o && rtr_i;
      if (rts_o) rts_seen = 1;
      if (mem_en_o) begin
        addr_obs_q.push_back(mem_addr_o);
        if (issued - xfers - int'(xfer_now) >= 2) credit_err++;
        issued++;
      end
      if (xfer_now) begin
        obs_q.push_back({sow_o, eow_o, data_o});
        obs_cyc_q.push_back(cyc);
        xfers++;
      end
      if (done_o) begin
        done_cyc_q.push_back(cyc);
        if (done_at < 0) done_at = cyc;
      end
      prev_stall = rts_o && !rtr_i;
      prev_out   = {sow_o, eow_o, data_o};
      if (abort_after > 0 && xfers >= abort_after) fin = 1;
      else if (done_at >= 0 && (!linger || cyc == done_at + 1)) begin
        if (linger) busy_after_done = busy_o;
        fin = 1;
      end else if (cyc >= 400) begin
        timed_out = 1;
        fin = 1;
      end
      cyc++;
    end
    start_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0; rtr_i = 1'b0;
    fill_mem(1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({busy_o, done_o, mem_en_o, mem_addr_o, rts_o, sow_o, eow_o, data_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b en=%b addr=%h rts=%b sow=%b eow=%b data=%h required all 0",
               busy_o, done_o, mem_en_o, mem_addr_o, rts_o, sow_o, eow_o, data_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    fill_mem(1);
    model_window(8'h10, 4);
    run_window(8'h10, 8'd4, 0, -1, 0, 1);
    checks++;
    if (timed_out || obs_q.size() != 4) begin
      failures++; $display("FAIL basic_count got=%0d required=4 timeout=%0d", obs_q.size(), timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_cyc_q[i] != 3 + i) begin
        failures++;
        $display("FAIL basic_word%0d got=%h@%0d required=%h@%0d", i,
                 (i < obs_q.size()) ? obs_q[i] : 'x, (i < obs_cyc_q.size()) ? obs_cyc_q[i] : -1,
                 exp_q[i], 3 + i);
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 7) begin
      failures++; $display("FAIL basic_done pulses=%0d first=%0d required one at 7",
                           done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1);
    end
    checks++;
    if (busy_after_done !== 1'b0) begin
      failures++; $display("FAIL basic_busy_c8 got=%b required=0", busy_after_done);
    end
    checks++;
    if (addr_obs_q !== exp_addr_q) begin
      failures++; $display("FAIL basic_addrs got=%p required=%p", addr_obs_q, exp_addr_q);
    end
  endtask

  task automatic test_backpressure;
    fill_mem(0);
    model_window(8'h33, 6);
    run_window(8'h33, 8'd6, 1, -1, 0, 0);
    checks++;
    if (timed_out || obs_q !== exp_q) begin
      failures++; $display("FAIL bp_words got=%p required=%p timeout=%0d", obs_q, exp_q, timed_out);
    end
    checks++;
    if (stable_err != 0) begin
      failures++; $display("FAIL bp_stable unstable_cycles=%0d required=0", stable_err);
    end
    checks++;
    if (credit_err != 0) begin
      failures++; $display("FAIL bp_credit overissued=%0d required=0", credit_err);
    end
    checks++;
    if (done_cyc_q.size() != 1 || obs_cyc_q.size() == 0 ||
        done_cyc_q[0] != obs_cyc_q[obs_cyc_q.size()-1] + 1) begin
      failures++; $display("FAIL bp_done pulses=%0d required one right after eow", done_cyc_q.size());
    end
  endtask

  task automatic test_single_empty;
    fill_mem(0);
    model_window(8'h77, 1);
    run_window(8'h77, 8'd1, 0, -1, 0, 0);
    checks++;
    if (timed_out || obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_q[0][OW-1 -: 2] !== 2'b11) begin
      failures++; $display("FAIL single_word got=%p required=%p", obs_q, exp_q);
    end
    run_window(8'h55, 8'd0, 0, -1, 0, 1);
    checks++;
    if (timed_out || rts_seen || obs_q.size() != 0 || addr_obs_q.size() != 0) begin
      failures++; $display("FAIL empty_no_data rts_seen=%0d words=%0d reads=%0d required 0",
                           rts_seen, obs_q.size(), addr_obs_q.size());
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] < 1 || done_cyc_q[0] > 2 || busy_after_done !== 1'b0) begin
      failures++; $display("FAIL empty_done pulses=%0d first=%0d busy_after=%b required one pulse by cycle 2",
                           done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, busy_after_done);
    end
  endtask

  task automatic test_wrap;
    fill_mem(0);
    model_window(8'hFE, 4);
    run_window(8'hFE, 8'd4, 2, -1, 0, 0);
    checks++;
    if (addr_obs_q !== exp_addr_q) begin
      failures++; $display("FAIL wrap_addrs got=%p required=%p", addr_obs_q, exp_addr_q);
    end
    checks++;
    if (timed_out || obs_q !== exp_q) begin
      failures++; $display("FAIL wrap_words got=%p required=%p", obs_q, exp_q);
    end
  endtask

  task automatic test_back_to_back;
    fill_mem(0);
    model_window(8'h20, 8);
    run_window(8'h20, 8'd8, 0, 4, 0, 0);
    checks++;
    if (timed_out || obs_q !== exp_q || done_cyc_q.size() != 1) begin
      failures++; $display("FAIL busy_start_ignored got=%p required=%p", obs_q, exp_q);
    end
    // Starts in the cycle right after done_o.
    model_window(8'h80, 3);
    run_window(8'h80, 8'd3, 0, -1, 0, 0);
    checks++;
    if (timed_out || obs_q !== exp_q || obs_cyc_q.size() == 0 || obs_cyc_q[0] != 3) begin
      failures++; $display("FAIL b2b_window got=%p required=%p first_cycle=%0d required=3",
                           obs_q, exp_q, (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1);
    end
  endtask

  task automatic test_random;
    logic [AW-1:0] b;
    int l;
    for (int n = 0; n < 8; n++) begin
      fill_mem(0);
      b = AW'($urandom);
      l = $urandom_range(1, 12);
      model_window(b, l);
      run_window(b, LW'(l), 2, -1, 0, 0);
      checks++;
      if (timed_out || obs_q !== exp_q || addr_obs_q !== exp_addr_q) begin
        failures++; $display("FAIL rand%0d_window base=%h len=%0d got=%p required=%p", n, b, l, obs_q, exp_q);
      end
      checks++;
      if (stable_err != 0 || credit_err != 0 || done_cyc_q.size() != 1) begin
        failures++; $display("FAIL rand%0d_proto unstable=%0d overissued=%0d done_pulses=%0d required 0,0,1",
                             n, stable_err, credit_err, done_cyc_q.size());
      end
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    fill_mem(0);
    run_window(8'h90, 8'd8, 0, -1, 2, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, mem_en_o, mem_addr_o, rts_o, sow_o, eow_o, data_o} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got busy=%b done=%b en=%b addr=%h rts=%b data=%h required all 0",
               busy_o, done_o, mem_en_o, mem_addr_o, rts_o, data_o);
    end
    bad = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (done_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    if (done_o !== 1'b0 || busy_o !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL midreset_no_done bad_cycles=%0d required=0", bad);
    end
    model_window(8'hC3, 5);
    run_window(8'hC3, 8'd5, 2, -1, 0, 1);
    checks++;
    if (timed_out || obs_q !== exp_q || done_cyc_q.size() != 1 || busy_after_done !== 1'b0) begin
      failures++; $display("FAIL midreset_recover got=%p required=%p", obs_q, exp_q);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_single_empty();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
